// File: rtl/arbitro_registrador.sv
// Round-robin arbiter that time-shares one 8-bit register between N_REQ requesters.
// The register's input recirculates its own output unless the current owner writes.
module arbitro_registrador #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 4,
  localparam int OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        wr_en,
  input  logic [N_REQ*DATA_W-1:0] wr_data,
  input  logic [DATA_W-1:0]       reg_saida,
  output logic [DATA_W-1:0]       reg_entrada,
  output logic [N_REQ-1:0]        gnt,
  output logic [OW-1:0]           owner_id,
  output logic                    busy,
  output logic [N_REQ-1:0]        wr_ack,
  output logic                    err
);

  localparam logic IDLE = 1'b0;
  localparam logic OWN  = 1'b1;

  logic             r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [OW-1:0]    r_owner;
  logic             r_busy;
  logic [N_REQ-1:0] r_wr_ack;
  logic             r_err;
  logic [OW-1:0]    r_ptr;
  logic [3:0]       r_hold;

  logic             w_found;
  logic [OW-1:0]    w_win;
  logic             w_own_wr;
  logic             w_leave;
  int               w_idx;

  // First requesting index at or above the pointer, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = (int'(r_ptr) + k) % N_REQ;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = OW'(w_idx);
      end
    end
  end

  always_comb begin
    w_own_wr    = r_busy & wr_en[r_owner];
    reg_entrada = w_own_wr ? wr_data[DATA_W*int'(r_owner) +: DATA_W] : reg_saida;
  end

  assign w_leave = !req[r_owner] || (r_hold == 4'(MAX_HOLD - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_gnt    <= '0;
      r_owner  <= '0;
      r_busy   <= 1'b0;
      r_wr_ack <= '0;
      r_err    <= 1'b0;
      r_ptr    <= '0;
      r_hold   <= '0;
    end else begin
      // Grant is only ever set on the owner's bit, so gnt masks legal writes.
      r_wr_ack <= r_gnt & wr_en;
      r_err    <= |(wr_en & ~r_gnt);
      case (r_state)
        IDLE: begin
          if (w_found) begin
            r_state <= OWN;
            r_gnt   <= N_REQ'(1) << w_win;
            r_owner <= w_win;
            r_busy  <= 1'b1;
            r_hold  <= '0;
          end
        end
        OWN: begin
          if (w_leave) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_owner <= '0;
            r_hold  <= '0;
            r_ptr   <= (r_owner == OW'(N_REQ - 1)) ? '0 : r_owner + 1'b1;
          end else begin
            r_hold  <= r_hold + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign owner_id = r_owner;
  assign busy     = r_busy;
  assign wr_ack   = r_wr_ack;
  assign err      = r_err;

endmodule
